// File: rtl/i2s_pwm_sequencer.sv
// rtl/i2s_pwm_sequencer.sv - I2S-to-PWM sequencer: period counter, one-deep sample buffer, duty load, underrun and mute
module i2s_pwm_sequencer #(
    parameter int SAMPLE_W      = 16,
    parameter int PWM_W         = 8,
    parameter int STALL_PERIODS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       smp_valid,
    output logic                       smp_ready,
    input  logic signed [SAMPLE_W-1:0] smp_left,
    input  logic signed [SAMPLE_W-1:0] smp_right,
    output logic        [PWM_W-1:0]    pwm_cnt,
    output logic                       period_start,
    output logic        [PWM_W-1:0]    duty_l,
    output logic        [PWM_W-1:0]    duty_r,
    output logic                       underrun,
    output logic                       muted
);

    localparam logic [PWM_W-1:0] MID       = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic [PWM_W-1:0] CNT_MAX   = '1;
    localparam logic [7:0]       STALL_LIM = 8'(STALL_PERIODS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_MUTE = 2'd2
    } state_t;

    state_t           r_state;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic             r_pend_full;
    logic [PWM_W-1:0] r_pend_l;
    logic [PWM_W-1:0] r_pend_r;
    logic [7:0]       r_stall_cnt;
    logic [PWM_W-1:0] r_duty_l;
    logic [PWM_W-1:0] r_duty_r;
    logic             r_underrun;
    logic             r_muted;

    logic             w_ready;
    logic             w_xfer;
    logic             w_boundary;
    logic             w_have_data;
    logic [PWM_W-1:0] w_conv_l;
    logic [PWM_W-1:0] w_conv_r;
    logic [PWM_W-1:0] w_load_l;
    logic [PWM_W-1:0] w_load_r;

    // Offset-binary: keep the top PWM_W bits and flip the sign bit.
    function automatic logic [PWM_W-1:0] to_duty(input logic [SAMPLE_W-1:0] s);
        return s[SAMPLE_W-1 -: PWM_W] ^ MID;
    endfunction

    generate
        if (SAMPLE_W > PWM_W) begin : g_trunc
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^{smp_left[SAMPLE_W-PWM_W-1:0], smp_right[SAMPLE_W-PWM_W-1:0]};
        end
    endgenerate

    assign w_ready     = (r_state != S_IDLE) && !r_pend_full;
    assign w_xfer      = smp_valid && w_ready;
    assign w_boundary  = (r_state != S_IDLE) && (r_pwm_cnt == CNT_MAX);
    assign w_have_data = r_pend_full || w_xfer;
    assign w_conv_l    = to_duty(smp_left);
    assign w_conv_r    = to_duty(smp_right);
    // A full pending buffer forces ready low, so a boundary transfer only happens when bypassing.
    assign w_load_l    = r_pend_full ? r_pend_l : w_conv_l;
    assign w_load_r    = r_pend_full ? r_pend_r : w_conv_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pwm_cnt   <= '0;
            r_pend_full <= 1'b0;
            r_pend_l    <= MID;
            r_pend_r    <= MID;
            r_stall_cnt <= '0;
            r_duty_l    <= MID;
            r_duty_r    <= MID;
            r_underrun  <= 1'b0;
            r_muted     <= 1'b1;
        end else begin
            r_underrun <= 1'b0;
            if (!enable) begin
                r_state     <= S_IDLE;
                r_pwm_cnt   <= '0;
                r_pend_full <= 1'b0;
                r_stall_cnt <= '0;
                r_duty_l    <= MID;
                r_duty_r    <= MID;
                r_muted     <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_RUN;
                        r_muted <= 1'b0;
                    end
                    S_RUN, S_MUTE: begin
                        r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
                        if (w_boundary) begin
                            if (w_have_data) begin
                                r_duty_l    <= w_load_l;
                                r_duty_r    <= w_load_r;
                                r_pend_full <= 1'b0;
                                r_stall_cnt <= '0;
                                r_state     <= S_RUN;
                                r_muted     <= 1'b0;
                            end else if (r_state == S_RUN) begin
                                r_underrun <= 1'b1;
                                if (r_stall_cnt != 8'hFF) begin
                                    r_stall_cnt <= r_stall_cnt + 8'd1;
                                end
                                if (r_stall_cnt + 8'd1 == STALL_LIM) begin
                                    r_state  <= S_MUTE;
                                    r_muted  <= 1'b1;
                                    r_duty_l <= MID;
                                    r_duty_r <= MID;
                                end
                            end
                        end else if (w_xfer) begin
                            r_pend_l    <= w_conv_l;
                            r_pend_r    <= w_conv_r;
                            r_pend_full <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_muted <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign smp_ready    = w_ready;
    assign pwm_cnt      = r_pwm_cnt;
    assign period_start = (r_state != S_IDLE) && (r_pwm_cnt == '0);
    assign duty_l       = r_duty_l;
    assign duty_r       = r_duty_r;
    assign underrun     = r_underrun;
    assign muted        = r_muted;

endmodule

// File: tb/tb_i2s_pwm_sequencer.sv
// tb/tb_i2s_pwm_sequencer.sv - Directed vector bench for i2s_pwm_sequencer (PWM_W=4, STALL_PERIODS=3)
module tb_i2s_pwm_sequencer;

    localparam int SW = 16;
    localparam int PW = 4;
    localparam int SP = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          smp_valid = 1'b0;
    logic          smp_ready;
    logic [SW-1:0] smp_left = '0;
    logic [SW-1:0] smp_right = '0;
    logic [PW-1:0] pwm_cnt;
    logic          period_start;
    logic [PW-1:0] duty_l;
    logic [PW-1:0] duty_r;
    logic          underrun;
    logic          muted;

    i2s_pwm_sequencer #(.SAMPLE_W(SW), .PWM_W(PW), .STALL_PERIODS(SP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .smp_valid    (smp_valid),
        .smp_ready    (smp_ready),
        .smp_left     (smp_left),
        .smp_right    (smp_right),
        .pwm_cnt      (pwm_cnt),
        .period_start (period_start),
        .duty_l       (duty_l),
        .duty_r       (duty_r),
        .underrun     (underrun),
        .muted        (muted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic [PW-1:0] dl;
        logic [PW-1:0] dr;
    } vec_t;

    vec_t vecs[5];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ps_cnt  = 0;
    int ur_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (period_start) ps_cnt <= ps_cnt + 1;
        if (underrun)     ur_cnt <= ur_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cnt(input logic [PW-1:0] target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pwm_cnt == target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_cnt_timeout", 0, 1);
    endtask

    task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r);
        check("push_ready", smp_ready, 1);
        smp_valid = 1'b1;
        smp_left  = l;
        smp_right = r;
        @(negedge clk);
        smp_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cnt"},   pwm_cnt, 0);
        check({tag, "_dl"},    duty_l, 8);
        check({tag, "_dr"},    duty_r, 8);
        check({tag, "_muted"}, muted, 1);
        check({tag, "_ready"}, smp_ready, 0);
        check({tag, "_ps"},    period_start, 0);
        check({tag, "_ur"},    underrun, 0);
    endtask

    initial begin
        int last_cyc;
        bit ok;

        vecs[0] = '{16'h7FFF, 16'h8000, 4'd15, 4'd0};
        vecs[1] = '{16'h0000, 16'hFFFF, 4'd8,  4'd7};
        vecs[2] = '{16'h4000, 16'hC000, 4'd12, 4'd4};
        vecs[3] = '{16'h1234, 16'hABCD, 4'd9,  4'd2};
        vecs[4] = '{16'h7000, 16'h8FFF, 4'd15, 4'd0};

        // Reset and idle
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_reset_outputs("idle");
        check("idle_ps_pulses", ps_cnt, 0);

        // Steady stream through the vector table
        enable = 1'b1;
        @(negedge clk);
        check("run_muted", muted, 0);
        check("run_ps", period_start, 1);
        last_cyc = cyc;
        for (int v = 0; v < 5; v++) begin
            wait_cnt(5);
            push(vecs[v].l, vecs[v].r);
            check("stream_ready_pend", smp_ready, 0);
            wait_cnt(0);
            check("stream_period_len", cyc - last_cyc, 16);
            last_cyc = cyc;
            check("stream_ps", period_start, 1);
            check("stream_dl", duty_l, vecs[v].dl);
            check("stream_dr", duty_r, vecs[v].dr);
            check("stream_ur", underrun, 0);
            check("stream_muted", muted, 0);
        end

        // Backpressure: second pair held off until the cycle after the boundary
        wait_cnt(3);
        push(16'h2000, 16'hE000);
        check("bp_ready_low", smp_ready, 0);
        smp_valid = 1'b1;
        smp_left  = 16'h5000;
        smp_right = 16'h9000;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (smp_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_ready_rise", ok, 1);
        check("bp_rise_cnt", pwm_cnt, 0);
        check("bp_a_dl", duty_l, 10);
        check("bp_a_dr", duty_r, 6);
        @(negedge clk);
        smp_valid = 1'b0;
        check("bp_b_pend", smp_ready, 0);
        wait_cnt(0);
        check("bp_b_dl", duty_l, 13);
        check("bp_b_dr", duty_r, 1);

        // Bypass on the boundary cycle
        wait_cnt(15);
        push(16'h3000, 16'hD000);
        check("byp_cnt", pwm_cnt, 0);
        check("byp_dl", duty_l, 11);
        check("byp_dr", duty_r, 5);
        check("byp_ready", smp_ready, 1);
        check("no_ur_so_far", ur_cnt, 0);

        // Starvation into MUTE and recovery
        for (int k = 1; k <= SP; k++) begin
            wait_cnt(0);
            check("stv_ur", underrun, 1);
            if (k < SP) begin
                check("stv_hold_dl", duty_l, 11);
                check("stv_hold_dr", duty_r, 5);
                check("stv_muted0", muted, 0);
            end else begin
                check("stv_mid_dl", duty_l, 8);
                check("stv_mid_dr", duty_r, 8);
                check("stv_muted1", muted, 1);
            end
        end
        wait_cnt(0);
        check("mute_no_ur", underrun, 0);
        check("mute_muted", muted, 1);
        check("stv_ur_total", ur_cnt, 3);
        wait_cnt(4);
        push(16'h4000, 16'h0000);
        wait_cnt(0);
        check("unmute_dl", duty_l, 12);
        check("unmute_dr", duty_r, 8);
        check("unmute_muted", muted, 0);
        check("unmute_ur", underrun, 0);

        // Disable with a pending pair discards it
        wait_cnt(4);
        push(16'h7FFF, 16'h7FFF);
        check("dis_pend", smp_ready, 0);
        enable = 1'b0;
        @(negedge clk);
        check_reset_outputs("dis");
        enable = 1'b1;
        @(negedge clk);
        check("reen_ready", smp_ready, 1);
        check("reen_muted", muted, 0);
        check("reen_ps", period_start, 1);
        wait_cnt(0);
        check("reen_ur", underrun, 1);
        check("reen_dl", duty_l, 8);
        check("reen_dr", duty_r, 8);

        // Transfer in the disable cycle is dropped
        enable    = 1'b0;
        smp_valid = 1'b1;
        smp_left  = 16'h7FFF;
        smp_right = 16'h7FFF;
        @(negedge clk);
        smp_valid = 1'b0;
        enable    = 1'b1;
        @(negedge clk);
        check("drop_ready", smp_ready, 1);

        // Asynchronous reset mid-period
        wait_cnt(2);
        push(16'h7FFF, 16'h8000);
        wait_cnt(0);
        check("pre_rst_dl", duty_l, 15);
        wait_cnt(5);
        push(16'h0000, 16'h0000);
        wait_cnt(7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
